kernel_sysid_checker: RTL and testbench

//  Avalon-MM master that sits directly upstream of the system-ID slave (1-bit address, 32-bit readdata).

---
 rtl/kernel_sysid_checker_pkg.sv | 19 +
 rtl/kernel_sysid_checker_if.sv | 10 +
 rtl/kernel_sysid_checker_rd_engine.sv | 67 ++++++
 rtl/kernel_sysid_checker.sv | 152 +++++++++++++++
 tb/tb_kernel_sysid_checker.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_sysid_checker_pkg.sv
// Shared types and constants for the system-ID build checker.
package kernel_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_DONE
  } sysid_chk_state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXP_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_EXP_TS = 32'd1534036031;

endpackage

// File: rtl/kernel_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface kernel_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave  (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/kernel_sysid_checker_rd_engine.sv
// Single Avalon read: holds the strobe through waitrequest, aborts after TIMEOUT
// stall cycles, and waits READ_LATENCY cycles after accept before signalling ack.
module kernel_sysid_rd_engine #(
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        addr,
  output logic        ack,
  output logic        tmo,
  output logic [31:0] data,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        pend_q, pend_d;
  logic        acc;

  always_comb begin
    avm_address = addr;
    avm_read    = req & ~pend_q;
    data        = avm_readdata;
    acc         = avm_read & ~avm_waitrequest;
    tmo         = avm_read & avm_waitrequest & (wait_cnt_q == 16'(TIMEOUT - 1));
    ack         = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    pend_d      = pend_q;

    // Stall counter restarts for every new read
    if (!req || acc || tmo) wait_cnt_d = '0;
    else if (avm_read)      wait_cnt_d = wait_cnt_q + 16'd1;

    if (!req) begin
      pend_d    = 1'b0;
      lat_cnt_d = '0;
    end else if (pend_q) begin
      if (lat_cnt_q == 2'(READ_LATENCY - 1)) begin
        ack       = 1'b1;
        pend_d    = 1'b0;
        lat_cnt_d = '0;
      end else begin
        lat_cnt_d = lat_cnt_q + 2'd1;
      end
    end else if (acc) begin
      if (READ_LATENCY == 0) ack = 1'b1;
      else                   pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      pend_q     <= pend_d;
    end
  end
endmodule

// File: rtl/kernel_sysid_checker.sv
// Reads sysid words 0/1 after reset or start and flags mismatch against the expected build.
// Define KERNEL_SYSID_PERIODIC_EN to re-run the check every RECHECK idle cycles.
module kernel_sysid_checker
  import kernel_sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID       = DEF_EXP_ID,
  parameter logic [31:0] EXP_TS       = DEF_EXP_TS,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] RECHECK      = 32'd1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  kernel_sysid_checker_if.master avm,
  output logic                   busy,
  output logic                   done,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout_err,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);
  sysid_chk_state_t state_q, state_d;
  logic        auto_q, auto_d;
  logic        req, addr, ack, tmo, acc, recheck_hit, clr_flags;
  logic [31:0] rd_data;
  logic        id_chk_q, ts_chk_q;
  logic        id_ok_q, ts_ok_q, tmo_err_q;
  logic [31:0] id_value_q, ts_value_q;

  kernel_sysid_rd_engine #(.READ_LATENCY(READ_LATENCY), .TIMEOUT(TIMEOUT)) u_rd (
    .clock(clock), .reset(reset), .req(req), .addr(addr),
    .ack(ack), .tmo(tmo), .data(rd_data),
    .avm_address(avm.avm_address), .avm_read(avm.avm_read),
    .avm_waitrequest(avm.avm_waitrequest), .avm_readdata(avm.avm_readdata)
  );

  assign acc = avm.avm_read & ~avm.avm_waitrequest;

  always_comb begin
    state_d   = state_q;
    auto_d    = auto_q;
    clr_flags = 1'b0;
    req       = 1'b0;
    addr      = ADDR_ID;
    unique case (state_q)
      S_IDLE: if (start || auto_q || recheck_hit) begin
        state_d   = S_RD_ID;
        auto_d    = 1'b0;
        clr_flags = 1'b1;
      end
      S_RD_ID: begin
        req = 1'b1;
        if (tmo)      state_d = S_DONE;
        else if (ack) state_d = S_RD_TS;
        else if (acc) state_d = S_LAT_ID;
      end
      S_LAT_ID: begin
        req = 1'b1;
        if (ack) state_d = S_RD_TS;
      end
      S_RD_TS: begin
        req  = 1'b1;
        addr = ADDR_TS;
        if (tmo || ack) state_d = S_DONE;
        else if (acc)   state_d = S_LAT_TS;
      end
      S_LAT_TS: begin
        req  = 1'b1;
        addr = ADDR_TS;
        if (ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      auto_q     <= 1'b1;
      id_chk_q   <= 1'b0;
      ts_chk_q   <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      id_chk_q <= ack & (addr == ADDR_ID);
      ts_chk_q <= ack & (addr == ADDR_TS);
      if (ack && addr == ADDR_ID) id_value_q <= rd_data;
      if (ack && addr == ADDR_TS) ts_value_q <= rd_data;
      // Compare runs one cycle behind capture, off the registered word
      if (clr_flags) begin
        id_ok_q   <= 1'b0;
        ts_ok_q   <= 1'b0;
        tmo_err_q <= 1'b0;
      end else begin
        if (id_chk_q) id_ok_q <= (id_value_q == EXP_ID);
        if (ts_chk_q) ts_ok_q <= (ts_value_q == EXP_TS);
        if (tmo)      tmo_err_q <= 1'b1;
      end
    end
  end

`ifdef KERNEL_SYSID_PERIODIC_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        per_run_q, per_run_d;

  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    per_run_d   = per_run_q | (state_q == S_DONE);
    recheck_hit = 1'b0;
    if (start || state_q == S_DONE) begin
      idle_cnt_d = '0;
    end else if (state_q == S_IDLE && per_run_q) begin
      if (idle_cnt_q == RECHECK - 32'd1) begin
        recheck_hit = 1'b1;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      per_run_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      per_run_q  <= per_run_d;
    end
  end
`else
  logic unused_recheck;
  assign recheck_hit    = 1'b0;
  assign unused_recheck = ^RECHECK;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Scoreboard bench for kernel_sysid_checker: zero-latency DUT with a stallable slave,
// plus a READ_LATENCY=2 DUT with a delayed-data slave.
module tb_kernel_sysid_checker;
  import kernel_sysid_pkg::*;

  localparam logic [31:0] EXP_TS_C  = 32'd1534036031;
  localparam int          RECHECK_C = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  kernel_sysid_checker_if bus ();
  kernel_sysid_checker_if bus2 ();

  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        busy2, done2, id_ok2, ts_ok2, timeout_err2;
  logic [31:0] id_value2, ts_value2;

  kernel_sysid_checker #(.READ_LATENCY(0), .TIMEOUT(4), .RECHECK(32'(RECHECK_C))) dut (
    .clock(clk), .reset(rst), .start(start), .avm(bus),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value)
  );

  kernel_sysid_checker #(.READ_LATENCY(2), .TIMEOUT(4), .RECHECK(32'(RECHECK_C))) dut_lat (
    .clock(clk), .reset(rst), .start(start2), .avm(bus2),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2), .timeout_err(timeout_err2),
    .id_value(id_value2), .ts_value(ts_value2)
  );

  // Slave for dut: programmable stall count per read, or stuck waitrequest
  int          stall_n = 0;
  int          stall_cnt = 0;
  logic        stuck = 1'b0;
  logic [31:0] id_word = 32'h0;
  logic [31:0] ts_word = EXP_TS_C;
  always @(posedge clk) stall_cnt <= (bus.avm_read && bus.avm_waitrequest) ? stall_cnt + 1 : 0;
  assign bus.avm_waitrequest = stuck | (bus.avm_read & (stall_cnt < stall_n));
  assign bus.avm_readdata    = !bus.avm_read ? 32'hDEAD_BEEF :
                               (bus.avm_address ? ts_word : id_word);

  // Slave for dut_lat: data valid only exactly two cycles after accept
  logic p1 = 1'b0, p2 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  always @(posedge clk) begin
    p1 <= bus2.avm_read & ~bus2.avm_waitrequest;
    a1 <= bus2.avm_address;
    p2 <= p1;
    a2 <= a1;
  end
  assign bus2.avm_waitrequest = 1'b0;
  assign bus2.avm_readdata    = p2 ? (a2 ? EXP_TS_C : 32'h0) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          ref_cyc;
    int          lat;
    logic        iok;
    logic        tok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  task automatic expect_chk(input int r, input int lat, input logic iok, input logic tok,
                            input logic tmo, input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    e.ref_cyc = r; e.lat = lat; e.iok = iok; e.tok = tok; e.tmo = tmo; e.idv = idv; e.tsv = tsv;
    sb.push_back(e);
  endtask

  int n_done = 0;
  int last_done = 0;

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      last_done = cyc;
      if (sb.size() == 0) begin
        check_val("unexp_done", {31'b0, done}, 32'd0);
      end else begin
        cur = sb.pop_front();
        check_val("done_cycle", 32'(cyc - cur.ref_cyc), 32'(cur.lat));
        @(negedge clk);
        check_val("busy_after_done", {31'b0, busy}, 32'd0);
        check_val("id_ok", {31'b0, id_ok}, {31'b0, cur.iok});
        check_val("ts_ok", {31'b0, ts_ok}, {31'b0, cur.tok});
        check_val("timeout_err", {31'b0, timeout_err}, {31'b0, cur.tmo});
        check_val("id_value", id_value, cur.idv);
        check_val("ts_value", ts_value, cur.tsv);
      end
    end
  end

  // Avalon hold rule while stalled, and strobe count during a stuck slave
  logic prev_stall = 1'b0;
  logic prev_addr = 1'b0;
  int   rd_hi = 0;
  always @(negedge clk) begin
    if (prev_stall && !stuck && !rst) begin
      check_val("rd_hold", {31'b0, bus.avm_read}, 32'd1);
      check_val("addr_hold", {31'b0, bus.avm_address}, {31'b0, prev_addr});
    end
    prev_stall = bus.avm_read & bus.avm_waitrequest;
    prev_addr  = bus.avm_address;
    if (bus.avm_read && stuck) rd_hi++;
  end

  int   rel = 0;
  logic d2_armed = 1'b0;
  always @(negedge clk) begin
    if (done2 && d2_armed) begin
      d2_armed = 1'b0;
      check_val("lat_done_cycle", 32'(cyc - rel), 32'd7);
      @(negedge clk);
      check_val("lat_id_ok", {31'b0, id_ok2}, 32'd1);
      check_val("lat_ts_ok", {31'b0, ts_ok2}, 32'd1);
      check_val("lat_id_value", id_value2, 32'h0);
      check_val("lat_ts_value", ts_value2, EXP_TS_C);
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check_val("drain_wait", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk);
    #1 start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_id_ok", {31'b0, id_ok}, 32'd0);
    check_val("rst_ts_ok", {31'b0, ts_ok}, 32'd0);
    check_val("rst_timeout", {31'b0, timeout_err}, 32'd0);
    check_val("rst_id_value", id_value, 32'h0);
    check_val("rst_ts_value", ts_value, 32'h0);
    check_val("rst_read", {31'b0, bus.avm_read}, 32'd0);

    // Auto check after reset release, zero-wait slave
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    d2_armed = 1'b1;
    expect_chk(rel, 3, 1'b1, 1'b1, 1'b0, 32'h0, EXP_TS_C);
    drain();

    // Mismatched timestamp
    ts_word = 32'h5B70_0000;
    pulse_start(t);
    expect_chk(t, 3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5B70_0000);
    drain();
    ts_word = EXP_TS_C;

    // Three stall cycles on each read
    stall_n = 3;
    pulse_start(t);
    expect_chk(t, 9, 1'b1, 1'b1, 1'b0, 32'h0, EXP_TS_C);
    drain();
    stall_n = 0;

    // Stuck waitrequest on the ID read; values must not be updated
    stuck = 1'b1;
    id_word = 32'h1234_5678;
    rd_hi = 0;
    pulse_start(t);
    expect_chk(t, 5, 1'b0, 1'b0, 1'b1, 32'h0, EXP_TS_C);
    drain();
    check_val("tmo_read_cycles", 32'(rd_hi), 32'd4);
    stuck = 1'b0;
    id_word = 32'h0;

    // Start held into the busy period is dropped: exactly one done
    @(posedge clk);
    #1 start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 check_val("busy_on_restart", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    expect_chk(t, 3, 1'b1, 1'b1, 1'b0, 32'h0, EXP_TS_C);
    drain();
    repeat (10) @(posedge clk);

    // Reset asserted during the timestamp read
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2;
    check_val("rd_ts_read", {31'b0, bus.avm_read}, 32'd1);
    check_val("rd_ts_addr", {31'b0, bus.avm_address}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_read", {31'b0, bus.avm_read}, 32'd0);
    check_val("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_val("mid_rst_id_ok", {31'b0, id_ok}, 32'd0);
    check_val("mid_rst_ts_ok", {31'b0, ts_ok}, 32'd0);
    check_val("mid_rst_timeout", {31'b0, timeout_err}, 32'd0);
    check_val("mid_rst_ts_value", ts_value, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    d2_armed = 1'b1;
    expect_chk(rel, 3, 1'b1, 1'b1, 1'b0, 32'h0, EXP_TS_C);
    drain();

`ifdef KERNEL_SYSID_PERIODIC_EN
    expect_chk(last_done, RECHECK_C + 3, 1'b1, 1'b1, 1'b0, 32'h0, EXP_TS_C);
    drain();
    check_val("done_count", 32'(n_done), 32'd7);
`else
    repeat (40) @(posedge clk);
    check_val("done_count", 32'(n_done), 32'd6);
`endif
    check_val("lat_all_seen", {31'b0, d2_armed}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
